mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Memory-stage consumer of the execute stage outputs (effective address, store data, opcode). Turns one load/store per request into a word-wide data-memory bus transaction with byte enables, then waits for the memory acknowledge. Returns load data sign- or zero-extended for writeback. Stalls upstream while a transaction is outstanding and flags misaligned accesses without touching the bus.

Parameters:
- ADDR_W, 32, byte-address width of ea.
- TIMEOUT_CYC, 255, cycles to wait for mem_ack before a bus error; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ex_valid  in  1  request from execute is present this cycle.
- ex_opc  in  6  MIPS opcode: 0x20 lb, 0x21 lh, 0x23 lw, 0x24 lbu, 0x25 lhu, 0x28 sb, 0x29 sh, 0x2B sw.
- ex_ea  in  ADDR_W  effective address (byte).
- ex_dm_in  in  32  store data from rt (right-aligned).
- ex_ready  out  1  unit can accept a request; low means stall upstream.
- mem_req  out  1  bus request; held until mem_ack.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W-2  word address, ea[ADDR_W-1:2].
- mem_be  out  4  byte enables; be[3] = bits 31:24.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  one-cycle completion strobe.
- mem_rdata  in  32  read word, valid with mem_ack.
- wb_valid  out  1  one-cycle completion pulse.
- wb_data  out  32  extended load result; 0 for stores.
- wb_exc  out  2  00 none, 01 AdEL, 10 AdES, 11 bus error; valid with wb_valid.

Behaviour:
- Big-endian: byte offset 0 maps to bits 31:24.
- Reset: FSM to IDLE; all outputs 0 except ex_ready = 1; capture registers cleared.
- FSM states:
  - IDLE: ex_ready = 1. Accept when ex_valid and ex_opc is one of the 8 memory opcodes; any other opcode is ignored.
  - IDLE, accepted and misaligned (halfword with ea[0] = 1, word with ea[1:0] != 0): go to DONE with wb_exc = AdEL (loads) or AdES (stores). mem_req is never asserted.
  - IDLE, accepted and aligned: latch opc and ea[1:0], drive the bus registers, go to BUS.
  - BUS: mem_req = 1, ex_ready = 0. Address, we, be and wdata stay stable until mem_ack. On mem_ack, capture mem_rdata, drop mem_req in the next cycle, go to DONE.
  - DONE: wb_valid = 1 for exactly one cycle, wb_data and wb_exc valid, ex_ready = 0. Next state is IDLE.
- Latency:
  - Aligned access: mem_req rises 1 cycle after acceptance; wb_valid follows 1 cycle after mem_ack; back-to-back accept is possible the cycle after DONE.
  - Misaligned access: wb_valid 1 cycle after acceptance.
- Byte enables: byte = 1000 >> ea[1:0]; half = ea[1] ? 0011 : 1100; word = 1111.
- Write data: sb replicates dm_in[7:0] to all 4 lanes; sh replicates dm_in[15:0] to both halves; sw passes dm_in unchanged.
- Load extraction uses the latched ea[1:0]. lb/lh sign-extend; lbu/lhu zero-extend.
- mem_ack outside BUS is ignored.
- Reset mid-BUS drops mem_req in the same edge; no wb_valid is produced.

Optional Feature:
MEM_TIMEOUT_EN
- Defined: an 8-bit counter, cleared on entry to BUS, increments each cycle in BUS. Reaching TIMEOUT_CYC without mem_ack drops mem_req and goes to DONE with wb_exc = 11 and wb_data = 0. An ack arriving in the same cycle as the timeout wins.
- Undefined: BUS waits for mem_ack indefinitely and the counter logic is absent.

Decomposition:
- Shared package mips_mem_pkg:
  - opcode constants OPC_LB … OPC_SW;
  - wb_exc encodings EXC_NONE, EXC_ADEL, EXC_ADES, EXC_BUSERR;
  - FSM state constants S_IDLE, S_BUS, S_DONE.
- One natural sub-module: mem_lane_align, purely combinational. It covers be generation, wdata replication and load extract/extend, so both directions can be unit-tested in isolation.

Test Plan:
- sw, ea = 0x0000_1004, dm_in = 0xDEADBEEF, ack after 2 cycles: mem_addr = 0x401, be = 1111, wdata = 0xDEADBEEF, we = 1; wb_valid 1 cycle after ack, wb_exc = 00.
- lb at ea offset 1, mem_rdata = 0x11_F2_33_44: wb_data = 0xFFFF_FFF2. lbu at the same address: wb_data = 0x0000_00F2.
- sh, ea = 0x...02, dm_in = 0x0000_ABCD: be = 0011, wdata = 0xABCD_ABCD. Then lh at the same address with rdata 0x0000_8001: wb_data = 0xFFFF_8001.
- lw at ea = 0x...06: no mem_req, wb_valid next cycle, wb_exc = 01. sh at ea = 0x...03: wb_exc = 10.
- ex_valid held high during BUS: ex_ready = 0 and the second request is accepted only after DONE. Reset asserted mid-BUS: mem_req = 0 next edge, no wb_valid.
- MEM_TIMEOUT_EN with TIMEOUT_CYC = 4, no ack: mem_req high for 4 cycles, then wb_exc = 11. Ack coinciding with the 4th cycle: normal completion.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared constants for the memory-access stage: MIPS load/store opcodes,
// writeback exception codes, FSM states and opcode classification helpers.
package mips_mem_pkg;

  localparam logic [5:0] OPC_LB  = 6'h20;
  localparam logic [5:0] OPC_LH  = 6'h21;
  localparam logic [5:0] OPC_LW  = 6'h23;
  localparam logic [5:0] OPC_LBU = 6'h24;
  localparam logic [5:0] OPC_LHU = 6'h25;
  localparam logic [5:0] OPC_SB  = 6'h28;
  localparam logic [5:0] OPC_SH  = 6'h29;
  localparam logic [5:0] OPC_SW  = 6'h2B;

  localparam logic [1:0] EXC_NONE   = 2'b00;
  localparam logic [1:0] EXC_ADEL   = 2'b01;
  localparam logic [1:0] EXC_ADES   = 2'b10;
  localparam logic [1:0] EXC_BUSERR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_mem_opc(input logic [5:0] opc);
    case (opc)
      OPC_LB, OPC_LH, OPC_LW, OPC_LBU, OPC_LHU,
      OPC_SB, OPC_SH, OPC_SW: is_mem_opc = 1'b1;
      default:                is_mem_opc = 1'b0;
    endcase
  endfunction

  function automatic logic is_load(input logic [5:0] opc);
    case (opc)
      OPC_LB, OPC_LH, OPC_LW, OPC_LBU, OPC_LHU: is_load = 1'b1;
      default:                                  is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [5:0] opc, input logic [1:0] off);
    case (opc)
      OPC_LH, OPC_LHU, OPC_SH: is_misaligned = off[0];
      OPC_LW, OPC_SW:          is_misaligned = (off != 2'b00);
      default:                 is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering: byte enables and store-data replication for
// the outgoing request, and extract/extend of the returned load word.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [5:0]  st_opc,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [5:0]  ld_opc,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be    = 4'b1111;
    wdata = 32'h0;
    case (st_opc)
      OPC_LB, OPC_LBU, OPC_SB: be = 4'b1000 >> st_off;
      OPC_LH, OPC_LHU, OPC_SH: be = st_off[1] ? 4'b0011 : 4'b1100;
      default:                 be = 4'b1111;
    endcase
    case (st_opc)
      OPC_SB:  wdata = {4{st_data[7:0]}};
      OPC_SH:  wdata = {2{st_data[15:0]}};
      OPC_SW:  wdata = st_data;
      default: wdata = 32'h0;
    endcase
  end

  // Offset 0 is the most significant byte.
  always_comb begin
    ld_byte = 8'h0;
    ld_data = 32'h0;
    case (ld_off)
      2'd0:    ld_byte = rdata[31:24];
      2'd1:    ld_byte = rdata[23:16];
      2'd2:    ld_byte = rdata[15:8];
      default: ld_byte = rdata[7:0];
    endcase
    ld_half = ld_off[1] ? rdata[15:0] : rdata[31:16];
    case (ld_opc)
      OPC_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      OPC_LBU: ld_data = {24'h0, ld_byte};
      OPC_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
      OPC_LHU: ld_data = {16'h0, ld_half};
      OPC_LW:  ld_data = rdata;
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: one load/store per request to a word-wide bus with byte enables.
// Define MEM_TIMEOUT_EN to add a bus-error timeout after TIMEOUT_CYC cycles in BUS.
//
// state  | meaning
// S_IDLE | ready; accept a memory opcode from execute
// S_BUS  | mem_req held with stable address/be/wdata until mem_ack
// S_DONE | one-cycle wb_valid with wb_data/wb_exc
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [5:0]        ex_opc,
  input  logic [ADDR_W-1:0] ex_ea,
  input  logic [31:0]       ex_dm_in,
  output logic              ex_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic [1:0]        wb_exc
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 256) begin : g_bad_timeout
    $error("TIMEOUT_CYC must fit the 8-bit BUS cycle counter");
  end

  state_t      state;
  logic [5:0]  opc_q;
  logic [1:0]  off_q;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] ld_data;

  mem_lane_align u_align (
    .st_opc  (ex_opc),
    .st_off  (ex_ea[1:0]),
    .st_data (ex_dm_in),
    .be      (be_next),
    .wdata   (wdata_next),
    .ld_opc  (opc_q),
    .ld_off  (off_q),
    .rdata   (mem_rdata),
    .ld_data (ld_data)
  );

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] bus_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      opc_q     <= 6'h0;
      off_q     <= 2'b00;
      ex_ready  <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
      wb_valid  <= 1'b0;
      wb_data   <= 32'h0;
      wb_exc    <= EXC_NONE;
`ifdef MEM_TIMEOUT_EN
      bus_cnt   <= 8'h0;
`endif
    end else begin
      wb_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ex_valid && is_mem_opc(ex_opc)) begin
            ex_ready <= 1'b0;
            if (is_misaligned(ex_opc, ex_ea[1:0])) begin
              state    <= S_DONE;
              wb_valid <= 1'b1;
              wb_data  <= 32'h0;
              wb_exc   <= is_load(ex_opc) ? EXC_ADEL : EXC_ADES;
            end else begin
              state     <= S_BUS;
              opc_q     <= ex_opc;
              off_q     <= ex_ea[1:0];
              mem_req   <= 1'b1;
              mem_we    <= ~is_load(ex_opc);
              mem_addr  <= ex_ea[ADDR_W-1:2];
              mem_be    <= be_next;
              mem_wdata <= wdata_next;
`ifdef MEM_TIMEOUT_EN
              bus_cnt   <= 8'h0;
`endif
            end
          end
        end
        S_BUS: begin
          if (mem_ack) begin
            state    <= S_DONE;
            mem_req  <= 1'b0;
            wb_valid <= 1'b1;
            wb_data  <= is_load(opc_q) ? ld_data : 32'h0;
            wb_exc   <= EXC_NONE;
          end
`ifdef MEM_TIMEOUT_EN
          // An ack in the final cycle takes the branch above and completes normally.
          else if (bus_cnt == TO_LAST) begin
            state    <= S_DONE;
            mem_req  <= 1'b0;
            wb_valid <= 1'b1;
            wb_data  <= 32'h0;
            wb_exc   <= EXC_BUSERR;
          end else begin
            bus_cnt <= bus_cnt + 8'd1;
          end
`endif
        end
        S_DONE: begin
          state    <= S_IDLE;
          ex_ready <= 1'b1;
          wb_data  <= 32'h0;
          wb_exc   <= EXC_NONE;
        end
        default: begin
          state    <= S_IDLE;
          ex_ready <= 1'b1;
          mem_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule
